// File: rtl/uart_host_bridge_if.sv
// Host byte streams plus the UART load/unload handshake seen by uart_host_bridge.
// The slave modport is the bridge's view; master is the surrounding environment.
interface uart_host_bridge_if #(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
);
  localparam int unsigned TX_LW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_LW = $clog2(RX_DEPTH) + 1;

  logic             tx_en;
  logic             rx_en;
  logic             s_tx_valid;
  logic             s_tx_ready;
  logic [7:0]       s_tx_data;
  logic             m_rx_valid;
  logic             m_rx_ready;
  logic [7:0]       m_rx_data;
  logic [TX_LW-1:0] tx_level;
  logic [RX_LW-1:0] rx_level;
  logic             ld_tx_data;
  logic [7:0]       tx_data;
  logic             tx_empty;
  logic             tx_enable;
  logic             uld_rx_data;
  logic [7:0]       rx_data;
  logic             rx_empty;
  logic             rx_enable;

  modport slave (
    input  tx_en, rx_en, s_tx_valid, s_tx_data, m_rx_ready, tx_empty, rx_data, rx_empty,
    output s_tx_ready, m_rx_valid, m_rx_data, tx_level, rx_level,
           ld_tx_data, tx_data, tx_enable, uld_rx_data, rx_enable
  );

  modport master (
    output tx_en, rx_en, s_tx_valid, s_tx_data, m_rx_ready, tx_empty, rx_data, rx_empty,
    input  s_tx_ready, m_rx_valid, m_rx_data, tx_level, rx_level,
           ld_tx_data, tx_data, tx_enable, uld_rx_data, rx_enable
  );
endinterface

// File: rtl/uart_host_bridge.sv
// Bridges valid/ready byte streams to a UART's load/unload handshake through
// a TX FIFO and an RX FIFO, each sequenced by a small FSM.
module uart_host_bridge #(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_host_bridge_if.slave bus
);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_LOAD = 2'd1, TX_WAIT = 2'd2} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_UNLOAD = 2'd1, RX_CAPTURE = 2'd2} rx_state_e;

  tx_state_e      r_tx_state, w_tx_next;
  rx_state_e      r_rx_state, w_rx_next;
  logic           r_in_reset;
  logic           r_ld_tx_data;
  logic           r_uld_rx_data;
  logic [7:0]     r_tx_data;
  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [7:0]     r_rx_mem [RX_DEPTH];
  logic [TX_AW:0] r_tx_wr, r_tx_rd, w_tx_level;
  logic [RX_AW:0] r_rx_wr, r_rx_rd, w_rx_level;
  logic           w_tx_ready, w_tx_push, w_tx_pop;
  logic           w_rx_valid, w_rx_push, w_rx_pop;

  // Wrap-bit pointers: the level MSB is set exactly when the FIFO is full.
  assign w_tx_level = r_tx_wr - r_tx_rd;
  assign w_rx_level = r_rx_wr - r_rx_rd;
  assign w_tx_ready = !r_in_reset && !w_tx_level[TX_AW];
  assign w_tx_push  = bus.s_tx_valid && w_tx_ready;
  assign w_rx_valid = (w_rx_level != '0);
  assign w_rx_pop   = w_rx_valid && bus.m_rx_ready;
  assign w_rx_push  = (r_rx_state == RX_CAPTURE);

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if ((w_tx_level != '0) && bus.tx_empty) begin
          w_tx_next = TX_LOAD;
          w_tx_pop  = 1'b1;
        end
      end
      TX_LOAD: w_tx_next = TX_WAIT;
      // Hold until the UART drops tx_empty so a second load cannot overrun it.
      TX_WAIT: if (!bus.tx_empty) w_tx_next = TX_IDLE;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:    if (!bus.rx_empty && !w_rx_level[RX_AW]) w_rx_next = RX_UNLOAD;
      RX_UNLOAD:  w_rx_next = RX_CAPTURE;
      RX_CAPTURE: w_rx_next = RX_IDLE;
      default:    w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_in_reset    <= 1'b1;
      r_tx_state    <= TX_IDLE;
      r_rx_state    <= RX_IDLE;
      r_ld_tx_data  <= 1'b0;
      r_uld_rx_data <= 1'b0;
      r_tx_data     <= '0;
      r_tx_wr       <= '0;
      r_tx_rd       <= '0;
      r_rx_wr       <= '0;
      r_rx_rd       <= '0;
    end else begin
      r_in_reset    <= 1'b0;
      r_tx_state    <= w_tx_next;
      r_rx_state    <= w_rx_next;
      r_ld_tx_data  <= (w_tx_next == TX_LOAD);
      r_uld_rx_data <= (w_rx_next == RX_UNLOAD);
      if (w_tx_push) r_tx_wr <= r_tx_wr + (TX_AW + 1)'(1);
      if (w_tx_pop) begin
        r_tx_rd   <= r_tx_rd + (TX_AW + 1)'(1);
        r_tx_data <= r_tx_mem[r_tx_rd[TX_AW-1:0]];
      end
      if (w_rx_push) r_rx_wr <= r_rx_wr + (RX_AW + 1)'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + (RX_AW + 1)'(1);
    end
  end

  // Storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[TX_AW-1:0]] <= bus.s_tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wr[RX_AW-1:0]] <= bus.rx_data;
  end

  assign bus.s_tx_ready  = w_tx_ready;
  assign bus.m_rx_valid  = w_rx_valid;
  assign bus.m_rx_data   = r_rx_mem[r_rx_rd[RX_AW-1:0]];
  assign bus.tx_level    = w_tx_level;
  assign bus.rx_level    = w_rx_level;
  assign bus.ld_tx_data  = r_ld_tx_data;
  assign bus.tx_data     = r_tx_data;
  assign bus.uld_rx_data = r_uld_rx_data;
  assign bus.tx_enable   = bus.tx_en;
  assign bus.rx_enable   = bus.rx_en;
endmodule
